// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared state encoding and frame constants for the UART RX controller
package uart_rx_pkg;

  localparam int DATA_WIDTH = 8;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// rtl/uart_rx_edge_bit_counter.sv - oversampling edge counter and bit counter with bit-end strobe
module uart_rx_edge_bit_counter #(
  parameter int PRESCALE_WIDTH = 6,
  parameter int BIT_CNT_WIDTH  = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      en,
  input  logic                      bit_clr,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic [PRESCALE_WIDTH-1:0] edge_cnt,
  output logic [BIT_CNT_WIDTH-1:0]  bit_cnt,
  output logic                      bit_end
);

  assign bit_end = en && (edge_cnt == prescale - PRESCALE_WIDTH'(1));

  // bit_clr lets the start bit end restart data indexing at bit 0
  always_ff @(posedge CLK) begin
    if (RST || !en) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (bit_end) begin
      edge_cnt <= '0;
      bit_cnt  <= bit_clr ? '0 : bit_cnt + BIT_CNT_WIDTH'(1);
    end else begin
      edge_cnt <= edge_cnt + PRESCALE_WIDTH'(1);
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART RX FSM, LSB-first deserialiser, parity and stop checks
// Optional parity support is built when UART_RX_PARITY_EN is defined.
module uart_rx_ctrl #(
  parameter int DATA_WIDTH     = uart_rx_pkg::DATA_WIDTH,
  parameter int PRESCALE_WIDTH = 6,
  parameter int BIT_CNT_WIDTH  = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic                      sampled_bit,
  output logic                      dat_samp_en,
  output logic [PRESCALE_WIDTH-1:0] edge_cnt,
  output logic [DATA_WIDTH-1:0]     P_DATA,
  output logic                      data_valid,
  output logic                      par_err,
  output logic                      stp_err
);

  import uart_rx_pkg::*;

  localparam int IDX_W = $clog2(DATA_WIDTH);

  state_t                   state;
  state_t                   after_data;
  logic                     bit_end;
  logic [BIT_CNT_WIDTH-1:0] bit_cnt;
  logic                     par_err_q;

  uart_rx_edge_bit_counter #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH),
    .BIT_CNT_WIDTH (BIT_CNT_WIDTH)
  ) u_cnt (
    .CLK     (CLK),
    .RST     (RST),
    .en      (dat_samp_en),
    .bit_clr (state == START),
    .prescale(prescale),
    .edge_cnt(edge_cnt),
    .bit_cnt (bit_cnt),
    .bit_end (bit_end)
  );

`ifdef UART_RX_PARITY_EN
  assign after_data = PAR_EN ? PARITY : STOP;
`else
  logic unused_par_cfg;
  assign unused_par_cfg = PAR_EN ^ PAR_TYP;
  assign after_data     = STOP;
`endif

  assign par_err = par_err_q;

  always_ff @(posedge CLK) begin
    data_valid <= 1'b0;
    if (RST) begin
      state       <= IDLE;
      dat_samp_en <= 1'b0;
      P_DATA      <= '0;
      par_err_q   <= 1'b0;
      stp_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!RX_IN) begin
            state       <= START;
            dat_samp_en <= 1'b1;
            par_err_q   <= 1'b0;
            stp_err     <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            if (!sampled_bit) begin
              state <= DATA;
            end else begin
              state       <= IDLE;
              dat_samp_en <= 1'b0;
            end
          end
        end
        DATA: begin
          if (bit_end) begin
            P_DATA[bit_cnt[IDX_W-1:0]] <= sampled_bit;
            if (bit_cnt == BIT_CNT_WIDTH'(DATA_WIDTH - 1)) begin
              state <= after_data;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            par_err_q <= sampled_bit ^ (^P_DATA) ^ PAR_TYP;
            state     <= STOP;
          end
        end
`endif
        STOP: begin
          // par_err_q already holds this frame's result (or 0 when no parity bit)
          if (bit_end) begin
            stp_err     <= ~sampled_bit;
            data_valid  <= sampled_bit & ~par_err_q;
            state       <= IDLE;
            dat_samp_en <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          dat_samp_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - directed table-driven bench for uart_rx_ctrl with a 3-sample majority sampler
module tb_uart_rx_ctrl;

  import uart_rx_pkg::*;

`ifdef UART_RX_PARITY_EN
  localparam bit PAR_BUILT = 1'b1;
`else
  localparam bit PAR_BUILT = 1'b0;
`endif

  logic       CLK;
  logic       RST;
  logic       RX_IN;
  logic [5:0] prescale;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       sampled_bit;
  logic       dat_samp_en;
  logic [5:0] edge_cnt;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;

  uart_rx_ctrl dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .prescale   (prescale),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .sampled_bit(sampled_bit),
    .dat_samp_en(dat_samp_en),
    .edge_cnt   (edge_cnt),
    .P_DATA     (P_DATA),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stp_err    (stp_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic s0, s1;
  int   half;
  assign half = int'(prescale) / 2;

  always_ff @(posedge CLK) begin
    if (RST) begin
      s0          <= 1'b1;
      s1          <= 1'b1;
      sampled_bit <= 1'b1;
    end else if (dat_samp_en) begin
      if (int'(edge_cnt) == half - 1) s0 <= RX_IN;
      if (int'(edge_cnt) == half)     s1 <= RX_IN;
      if (int'(edge_cnt) == half + 1) sampled_bit <= (s0 & s1) | (s0 & RX_IN) | (s1 & RX_IN);
    end
  end

  int cyc;
  always_ff @(posedge CLK) begin
    if (RST) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  int         vcnt;
  int         fall_cyc;
  int         last_lat;
  logic [7:0] got_q[$];
  initial vcnt = 0;
  always @(negedge CLK) begin
    if (data_valid) begin
      vcnt     = vcnt + 1;
      last_lat = cyc - fall_cyc;
      got_q.push_back(P_DATA);
    end
  end

  int   checks;
  int   failures;
  logic snap_stp, snap_par;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input logic b, input int p);
    RX_IN = b;
    repeat (p) @(negedge CLK);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pe, input logic pbit,
                            input logic sbit, input int p);
    RX_IN    = 1'b0;
    fall_cyc = cyc;
    repeat (2) @(negedge CLK);
    snap_stp = stp_err;
    snap_par = par_err;
    repeat (p - 2) @(negedge CLK);
    for (int i = 0; i < 8; i++) drive_bit(d[i], p);
    if (pe) drive_bit(pbit, p);
    drive_bit(sbit, p);
  endtask

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) @(negedge CLK);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       par_en;
    logic       par_typ;
    logic       par_bit;
    logic       stop_bit;
    logic       exp_valid;
    logic       exp_par;
    logic       exp_stp;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int   v0;
    logic pe;
    logic ev, ep;

    vecs[0] = '{8'hA5, 1'b0, PAR_EVEN, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 1'b1, PAR_EVEN, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h3C, 1'b1, PAR_EVEN, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{8'h3C, 1'b1, PAR_ODD,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'h55, 1'b0, PAR_EVEN, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{8'h0F, 1'b0, PAR_EVEN, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{8'h80, 1'b1, PAR_ODD,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    checks   = 0;
    failures = 0;
    fall_cyc = 0;
    last_lat = 0;
    RST      = 1'b1;
    RX_IN    = 1'b1;
    prescale = 6'd8;
    PAR_EN   = 1'b0;
    PAR_TYP  = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("reset_samp_en", dat_samp_en, 0);
    chk("reset_edge_cnt", edge_cnt, 0);
    chk("reset_p_data", P_DATA, 0);
    chk("reset_valid", data_valid, 0);
    chk("reset_par_err", par_err, 0);
    chk("reset_stp_err", stp_err, 0);

    for (int i = 0; i < 7; i++) begin
      pe      = vecs[i].par_en & PAR_BUILT;
      ev      = PAR_BUILT ? vecs[i].exp_valid : vecs[i].stop_bit;
      ep      = PAR_BUILT ? vecs[i].exp_par : 1'b0;
      PAR_EN  = vecs[i].par_en;
      PAR_TYP = vecs[i].par_typ;
      v0      = vcnt;
      send_frame(vecs[i].data, pe, vecs[i].par_bit, vecs[i].stop_bit, 8);
      idle(24);
      chk($sformatf("v%0d_valid_cnt", i), vcnt - v0, ev ? 1 : 0);
      chk($sformatf("v%0d_p_data", i), P_DATA, vecs[i].data);
      chk($sformatf("v%0d_par_err", i), par_err, ep);
      chk($sformatf("v%0d_stp_err", i), stp_err, vecs[i].exp_stp);
      chk($sformatf("v%0d_err_clr_at_start", i), {snap_par, snap_stp}, 0);
      if (ev) chk($sformatf("v%0d_latency", i), last_lat, (10 + (pe ? 1 : 0)) * 8 + 1);
    end

    // start glitch: low for 3 cycles only
    v0    = vcnt;
    RX_IN = 1'b0;
    repeat (3) @(negedge CLK);
    RX_IN = 1'b1;
    repeat (5) @(negedge CLK);
    chk("glitch_samp_en_edge7", dat_samp_en, 1);
    chk("glitch_edge_cnt", edge_cnt, 7);
    @(negedge CLK);
    chk("glitch_back_idle", dat_samp_en, 0);
    idle(30);
    chk("glitch_no_pulse", vcnt - v0, 0);
    chk("glitch_no_err", {par_err, stp_err}, 0);

    // back-to-back frames at prescale 16
    prescale = 6'd16;
    PAR_EN   = 1'b0;
    idle(4);
    v0 = vcnt;
    got_q.delete();
    send_frame(8'h01, 1'b0, 1'b0, 1'b1, 16);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 16);
    idle(48);
    chk("b2b_pulses", vcnt - v0, 2);
    chk("b2b_byte0", (got_q.size() > 0) ? got_q[0] : 8'h00, 8'h01);
    chk("b2b_byte1", (got_q.size() > 1) ? got_q[1] : 8'h00, 8'hFF);

    // reset in the middle of data bit 4
    prescale = 6'd8;
    idle(4);
    v0    = vcnt;
    RX_IN = 1'b0;
    repeat (8) @(negedge CLK);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 8);
    repeat (4) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("rst_mid_samp_en", dat_samp_en, 0);
    chk("rst_mid_edge_cnt", edge_cnt, 0);
    chk("rst_mid_p_data", P_DATA, 0);
    chk("rst_mid_flags", {data_valid, par_err, stp_err}, 0);
    idle(30);
    chk("rst_mid_no_pulse", vcnt - v0, 0);
    send_frame(8'h81, 1'b0, 1'b0, 1'b1, 8);
    idle(24);
    chk("post_rst_pulse", vcnt - v0, 1);
    chk("post_rst_p_data", P_DATA, 8'h81);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
